// File: rtl/lfsr_stream_pkg.sv
// Shared constants and state encoding for the 64-tap shift-feedback stream checker.
// The bench's reference generator imports the same taps.
package lfsr_stream_pkg;

    localparam int unsigned HIST_W  = 64;
    localparam int unsigned TAP_HI  = 63;
    localparam int unsigned TAP_MID = 2;
    localparam int unsigned TAP_LO  = 0;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_stream_predict.sv
// Next-bit predictor: new = h[63] ^ h[2] ^ h[0].
// Purely combinational; the checker and the reference generator both use it.
module lfsr_stream_predict
    import lfsr_stream_pkg::*;
(
    input  logic [HIST_W-1:0] hist_i,
    output logic              pred_o
);

    logic unused_hist;

    assign pred_o      = hist_i[TAP_HI] ^ hist_i[TAP_MID] ^ hist_i[TAP_LO];
    // Only three taps feed the prediction; fold the rest into an unused net.
    assign unused_hist = ^hist_i;

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising receiver/checker for the 64-tap shift-feedback test stream.
// Seeds its history from the first 64 bits, then predicts, counts errors and reports lock.
module lfsr_stream_checker
    import lfsr_stream_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 128,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              resync,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  bit_count,
    output logic [1:0]        state,
    output logic [HIST_W-1:0] history
);

    localparam int unsigned SEED_W    = $clog2(HIST_W);
    localparam logic [1:0]  ST_SEED   = SEED;
    localparam logic [1:0]  ST_CHECK  = CHECK;
    localparam logic [1:0]  ST_LOCKED = LOCKED;

    logic [1:0]        state_q,     state_d;
    logic [SEED_W-1:0] seed_cnt_q,  seed_cnt_d;
    logic [CNT_W-1:0]  good_run_q,  good_run_d;
    logic [CNT_W-1:0]  bad_run_q,   bad_run_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [HIST_W-1:0] hist_q,      hist_d;
    logic              locked_q,    locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic              pred_c;

    lfsr_stream_predict u_predict (
        .hist_i (hist_q),
        .pred_o (pred_c)
    );

    // Next-state, counters and history update
    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        hist_d      = hist_q;
        err_pulse_d = 1'b0;

        if (resync) begin
            // History survives a resync; any bit presented alongside is dropped.
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            good_run_d  = '0;
            bad_run_d   = '0;
            err_count_d = '0;
            bit_count_d = '0;
        end else if (in_valid) begin
            hist_d = {hist_q[HIST_W-2:0], in_bit};
            if (bit_count_q != '1) begin
                bit_count_d = bit_count_q + CNT_W'(1);
            end
            case (state_q)
                ST_SEED: begin
                    if (seed_cnt_q == SEED_W'(HIST_W - 1)) begin
                        state_d    = ST_CHECK;
                        seed_cnt_d = '0;
                        good_run_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (in_bit == pred_c) begin
                        good_run_d = good_run_q + CNT_W'(1);
                        if (good_run_q + CNT_W'(1) == CNT_W'(LOCK_COUNT)) begin
                            state_d   = ST_LOCKED;
                            bad_run_d = '0;
                        end
                    end else begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (in_bit == pred_c) begin
                        bad_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (bad_run_q + CNT_W'(1) == CNT_W'(ERR_THRESH)) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            bad_run_d = bad_run_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEED;
            seed_cnt_q  <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            hist_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            hist_q      <= hist_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
    assign state     = state_q;
    assign history   = hist_q;

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Serial receiver and checker for the 64-tap shift-feedback test stream (new bit = s[63]^s[2]^s[0]) that our wide-register generator tests produce. It consumes one stream bit per valid cycle and self-synchronises by seeding its own 64-bit history from the incoming bits. It then predicts every following bit, counts mismatches, and reports lock status. It sits on the receive side of a generator/checker pair in regression benches, so wide shift streams are checked on the fly rather than compared as a single 4096-bit constant.

## Interface
- LOCK_COUNT, default 128: consecutive correct predictions needed to go from CHECK to LOCKED.
- ERR_THRESH, default 4: consecutive mispredictions in LOCKED that force a reseed.
- CNT_W, default 32: width of the counters.
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is presented this cycle.
- in_bit  input  1  stream bit; the newest generator bit (generator s[0] after its shift).
- resync  input  1  synchronous pulse; restart seeding.
- locked  output  1  state is LOCKED.
- err_pulse  output  1  one-cycle flag for a misprediction while LOCKED.
- err_count  output  CNT_W  saturating count of LOCKED mispredictions.
- bit_count  output  CNT_W  saturating count of accepted valid bits.
- state  output  2  SEED=0, CHECK=1, LOCKED=2.
- history  output  64  received-bit history; bit 0 is the newest.

## Operation
- Prediction: pred = history[63] ^ history[2] ^ history[0].
- On every accepted bit, history <= {history[62:0], in_bit}. The history always takes the received bit, never the predicted bit.
- Accepted bit means in_valid=1 and resync=0. Cycles with in_valid=0 change nothing.
- SEED:
  - seed_cnt counts accepted bits from 0 to 63, with no comparison.
  - On the 64th accepted bit: go to CHECK with good_run=0.
- CHECK:
  - in_bit==pred: good_run++. When good_run reaches LOCK_COUNT, go to LOCKED with bad_run=0.
  - in_bit!=pred: go to SEED with seed_cnt=0. err_count is not touched.
- LOCKED:
  - in_bit==pred: bad_run=0.
  - in_bit!=pred: err_pulse=1, err_count++ (saturates at all-ones), bad_run++. When bad_run reaches ERR_THRESH, go to SEED with seed_cnt=0 and locked=0.
- bit_count increments on every accepted bit in every state and saturates at all-ones.
- resync=1:
  - Next state SEED; clear seed_cnt, good_run, bad_run, err_count and bit_count.
  - history is kept.
  - A bit presented in the same cycle is discarded.
- Reset values: state SEED, locked 0, err_pulse 0, err_count 0, bit_count 0, history 0. Internal counters are also 0.

## Timing
- All outputs are registered. Results appear on the cycle after the accepted bit, with no combinational input-to-output path.
- err_pulse is high for exactly one cycle per mispredicted accepted bit. Back-to-back errors give a continuous high.
- locked rises on the cycle after the (64 + LOCK_COUNT)-th accepted bit of a clean stream counted from reset or resync: 192 with default parameters.
- locked falls on the cycle after the ERR_THRESH-th consecutive misprediction, and err_pulse is high in that same cycle.
- Reset asserted mid-stream clears everything immediately, asynchronously. Leaving reset is synchronous; the first accepted bit is on the first posedge after rst_n rises.

## Structure
- Package lfsr_stream_pkg holds:
  - the state enum (SEED, CHECK, LOCKED);
  - the tap constants TAP_HI=63, TAP_MID=2, TAP_LO=0;
  - the constant HIST_W=64.
- The generator test model imports the same tap constants.
- One sub-module, lfsr_stream_predict: purely combinational, takes history and returns pred. It is shared with the bench's reference generator.
- The FSM and counters live in the top module.

## Test plan
- Reset: hold rst_n=0 with in_valid toggling -> locked=0, err_pulse=0, counters=0, history=0, state=0. After release, the first accepted bit gives bit_count=1.
- Clean stream: generator seed 64'h1, 192 valid bits -> locked=1 on the cycle after bit 192, err_count=0, bit_count=192.
- Single flip after lock at stream bit k -> err_pulse at k, k+1, k+3, k+64 -> err_count=4, locked stays 1.
- After lock, drive 4 consecutive bits each equal to ~pred (bench computes pred from the history output) -> 4 err_pulses, locked=0 and state=SEED after the 4th, err_count=4.
- Clean stream with in_valid at 50% random duty -> lock after exactly 192 accepted bits, history unchanged on idle cycles.
- resync together with in_valid while LOCKED -> that bit is discarded; next cycle shows state=SEED, err_count=0, bit_count=0; relock after 192 further bits.
